// File: rtl/iomem_gpio_bank_if.sv
// PicoSoC iomem bus bundle: the CPU side drives the request, the peripheral
// answers with a one-cycle ready pulse carrying the read data.
interface iomem_gpio_bank_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid,
    output iomem_wstrb,
    output iomem_addr,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  modport slave (
    input  iomem_valid,
    input  iomem_wstrb,
    input  iomem_addr,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );
endinterface

// File: rtl/iomem_gpio_bank.sv
// WIDTH-pin GPIO bank on the iomem bus: data/direction registers, atomic
// SET/CLR/TOG, synchronised inputs and edge interrupts with W1C status.
module iomem_gpio_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [7:0]       BASE_ADDR   = 8'h03,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic                clk,
  input  logic                resetn,
  iomem_gpio_bank_if.slave    bus,
  input  logic [WIDTH-1:0]    gpio_in,
  output logic [WIDTH-1:0]    gpio_out,
  output logic [WIDTH-1:0]    gpio_oe,
  output logic                irq
);

  localparam logic [3:0] REG_DATA_OUT = 4'h0;
  localparam logic [3:0] REG_DATA_IN  = 4'h1;
  localparam logic [3:0] REG_DIR      = 4'h2;
  localparam logic [3:0] REG_SET      = 4'h3;
  localparam logic [3:0] REG_CLR      = 4'h4;
  localparam logic [3:0] REG_TOG      = 4'h5;
  localparam logic [3:0] REG_RISE_EN  = 4'h6;
  localparam logic [3:0] REG_FALL_EN  = 4'h7;
  localparam logic [3:0] REG_STATUS   = 4'h8;

  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [2:0]       prime_q, prime_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  logic             sel;
  logic             wr;
  logic [3:0]       reg_idx;
  logic [31:0]      lane_mask32;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [WIDTH-1:0] data_in;
  logic             primed;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] status_clr;
  logic [WIDTH-1:0] rd_val;
  logic             unused_bits;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] mask,
                                             input logic [WIDTH-1:0] bits);
    return (old & ~mask) | bits;
  endfunction

  // Decode the bus request; an access is taken only once, on the cycle ready is low.
  always_comb begin
    sel         = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == BASE_ADDR);
    reg_idx     = bus.iomem_addr[5:2];
    wr          = sel && (bus.iomem_wstrb != 4'b0000);
    lane_mask32 = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                   {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
    wmask       = lane_mask32[WIDTH-1:0];
    wbits       = bus.iomem_wdata[WIDTH-1:0] & wmask;
  end

  // Edge detection stays off until the synchroniser and prev have been refilled after reset.
  always_comb begin
    data_in = sync_q[SYNC_STAGES-1];
    primed  = (prime_q == PRIME_DONE);
    edges   = primed ? ((data_in & ~prev_q & rise_en_q) | (~data_in & prev_q & fall_en_q))
                     : '0;
  end

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_DATA_OUT: rd_val = data_out_q;
      REG_DATA_IN:  rd_val = data_in;
      REG_DIR:      rd_val = dir_q;
      REG_RISE_EN:  rd_val = rise_en_q;
      REG_FALL_EN:  rd_val = fall_en_q;
      REG_STATUS:   rd_val = status_q;
      default:      rd_val = '0;
    endcase
  end

  // Next-state: the read value above is pre-write, so a write returns the old contents.
  always_comb begin
    ready_d    = sel;
    rdata_d    = sel ? 32'(rd_val) : 32'h0;
    data_out_d = data_out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    status_clr = '0;
    prev_d     = data_in;
    prime_d    = primed ? prime_q : prime_q + 3'd1;
    sync_d[0]  = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    if (wr) begin
      case (reg_idx)
        REG_DATA_OUT: data_out_d = merge(data_out_q, wmask, wbits);
        REG_DIR:      dir_d      = merge(dir_q, wmask, wbits);
        REG_SET:      data_out_d = data_out_q | wbits;
        REG_CLR:      data_out_d = data_out_q & ~wbits;
        REG_TOG:      data_out_d = data_out_q ^ wbits;
        REG_RISE_EN:  rise_en_d  = merge(rise_en_q, wmask, wbits);
        REG_FALL_EN:  fall_en_d  = merge(fall_en_q, wmask, wbits);
        REG_STATUS:   status_clr = wbits;
        default:      ;
      endcase
    end
    status_d = (status_q & ~status_clr) | edges;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      data_out_q <= RESET_OUT;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      prev_q     <= '0;
      prime_q    <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      prev_q     <= prev_d;
      prime_q    <= prime_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign gpio_out        = data_out_q;
  assign gpio_oe         = dir_q;
  assign irq             = |status_q;

  assign unused_bits = &{1'b0, bus.iomem_addr[23:6], bus.iomem_addr[1:0],
                         bus.iomem_wdata, lane_mask32};

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Directed bench for iomem_gpio_bank: a cycle-level model built from the register
// rules is compared every cycle, plus hand-computed expectations per scenario.
module tb_iomem_gpio_bank;

  localparam int         WIDTH   = 8;
  localparam int         SYNC    = 2;
  localparam logic [7:0] BASE    = 8'h03;
  localparam logic [7:0] RST_OUT = 8'hA5;
  localparam logic [31:0] WMASK  = 32'h0000_00FF;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic             irq;

  iomem_gpio_bank_if bus();

  iomem_gpio_bank #(
    .WIDTH(WIDTH),
    .BASE_ADDR(BASE),
    .SYNC_STAGES(SYNC),
    .RESET_OUT(RST_OUT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe(gpio_oe),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int ready_pulses = 0;

  // Model state: register contents plus a history of sampled pin values.
  logic [31:0] m_out, m_dir, m_rise, m_fall, m_status, m_rdata;
  logic [31:0] pin_hist [SYNC+1];
  bit          m_ready = 1'b0;
  bit          m_valid = 1'b0;
  int          m_cycles = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  name, actual, expected, $time);
  endtask

  function automatic logic [31:0] regAddr(input logic [7:0] off);
    return {BASE, 16'h0000, off};
  endfunction

  // Model: DATA_IN is the pin value SYNC edges old; an edge is a change between
  // consecutive DATA_IN values, counted only once SYNC+1 edges have passed reset.
  initial begin : model
    logic [31:0] lanes, w, rd, din_now, din_prev, edges, clr;
    bit accept;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        m_out = 32'(RST_OUT); m_dir = 0; m_rise = 0; m_fall = 0; m_status = 0;
        m_rdata = 0; m_ready = 1'b0; m_cycles = 0; m_valid = 1'b1;
        for (int i = 0; i <= SYNC; i++) pin_hist[i] = 0;
      end else begin
        din_now  = pin_hist[SYNC-1];
        din_prev = pin_hist[SYNC];
        case (bus.iomem_addr[5:2])
          4'h0:    rd = m_out;
          4'h1:    rd = din_now;
          4'h2:    rd = m_dir;
          4'h6:    rd = m_rise;
          4'h7:    rd = m_fall;
          4'h8:    rd = m_status;
          default: rd = 0;
        endcase
        lanes  = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                  {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
        w      = bus.iomem_wdata & lanes & WMASK;
        accept = bus.iomem_valid && !m_ready && (bus.iomem_addr[31:24] == BASE);
        edges  = 0;
        if (m_cycles >= SYNC + 1)
          edges = ((din_now & ~din_prev & m_rise) | (~din_now & din_prev & m_fall)) & WMASK;
        clr = 0;
        if (accept && bus.iomem_wstrb != 4'b0000) begin
          case (bus.iomem_addr[5:2])
            4'h0:    m_out  = (m_out & ~lanes) | w;
            4'h2:    m_dir  = (m_dir & ~lanes) | w;
            4'h3:    m_out  = m_out | w;
            4'h4:    m_out  = m_out & ~w;
            4'h5:    m_out  = m_out ^ w;
            4'h6:    m_rise = (m_rise & ~lanes) | w;
            4'h7:    m_fall = (m_fall & ~lanes) | w;
            4'h8:    clr    = w;
            default: ;
          endcase
        end
        m_status = (m_status & ~clr) | edges;
        m_ready  = accept;
        m_rdata  = accept ? rd : 0;
        for (int i = SYNC; i > 0; i--) pin_hist[i] = pin_hist[i-1];
        pin_hist[0] = 32'(gpio_in);
        m_cycles++;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checkOutput("gpio_out", 32'(gpio_out), m_out);
        checkOutput("gpio_oe", 32'(gpio_oe), m_dir);
        checkOutput("irq", 32'(irq), 32'(m_status != 0));
        checkOutput("ready", 32'(bus.iomem_ready), 32'(m_ready));
        if (m_ready) checkOutput("rdata", bus.iomem_rdata, m_rdata);
      end
    end
  end

  initial begin : pulse_count
    forever begin
      @(negedge clk);
      if (bus.iomem_ready === 1'b1) ready_pulses++;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus access, started on a negedge; the ack outcome is itself a comparison.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input bit expect_ready,
                               output logic [31:0] rdata);
    bit got = 1'b0;
    rdata = 32'h0;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = wstrb;
    bus.iomem_wdata = wdata;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (bus.iomem_ready === 1'b1) begin
        got   = 1'b1;
        rdata = bus.iomem_rdata;
      end
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
    checkOutput("ack", 32'(got), 32'(expect_ready));
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] rd;
    int pulses0;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wdata = 32'h0;

    // Reset values
    resetn = 1'b0;
    waitCycles(3);
    resetn = 1'b1;
    checkOutput("oe after reset", 32'(gpio_oe), 32'h0);
    checkOutput("irq after reset", 32'(irq), 32'h0);
    applyStimulus(regAddr(8'h00), 4'h0, 32'h0, 1'b1, rd);
    checkOutput("reset DATA_OUT", rd, 32'h0000_00A5);
    applyStimulus(regAddr(8'h08), 4'h0, 32'h0, 1'b1, rd);
    checkOutput("reset DIR", rd, 32'h0);

    // Atomic set/clear/toggle
    pulses0 = ready_pulses;
    applyStimulus(regAddr(8'h00), 4'hF, 32'h0000_000F, 1'b1, rd);
    applyStimulus(regAddr(8'h0C), 4'hF, 32'h0000_00F0, 1'b1, rd);
    applyStimulus(regAddr(8'h10), 4'hF, 32'h0000_0003, 1'b1, rd);
    applyStimulus(regAddr(8'h14), 4'hF, 32'h0000_0081, 1'b1, rd);
    checkOutput("set/clr/tog out", 32'(gpio_out), 32'h0000_007D);
    applyStimulus(regAddr(8'h0C), 4'h0, 32'h0, 1'b1, rd);
    checkOutput("read SET", rd, 32'h0);
    waitCycles(1);
    checkOutput("ready pulses", 32'(ready_pulses - pulses0), 32'd5);
    applyStimulus(regAddr(8'h00), 4'hF, 32'h0000_0011, 1'b1, rd);
    checkOutput("read-before-write", rd, 32'h0000_007D);
    checkOutput("written out", 32'(gpio_out), 32'h0000_0011);

    // Byte strobes and width masking
    applyStimulus(regAddr(8'h08), 4'b0010, 32'h1234_5678, 1'b1, rd);
    applyStimulus(regAddr(8'h08), 4'h0, 32'h0, 1'b1, rd);
    checkOutput("DIR lane1 masked", rd, 32'h0);
    applyStimulus(regAddr(8'h08), 4'b0001, 32'h0000_00C3, 1'b1, rd);
    checkOutput("oe lane0", 32'(gpio_oe), 32'h0000_00C3);
    applyStimulus(regAddr(8'h00), 4'b1110, 32'hFFFF_FF22, 1'b1, rd);
    checkOutput("out lane0 off", 32'(gpio_out), 32'h0000_0011);

    // Rising edge latency and W1C
    applyStimulus(regAddr(8'h18), 4'hF, 32'h0000_0001, 1'b1, rd);
    gpio_in = 8'h01;
    waitCycles(1);
    checkOutput("irq n+1", 32'(irq), 32'h0);
    waitCycles(1);
    checkOutput("irq n+2", 32'(irq), 32'h0);
    waitCycles(1);
    checkOutput("irq n+3", 32'(irq), 32'h1);
    applyStimulus(regAddr(8'h04), 4'h0, 32'h0, 1'b1, rd);
    checkOutput("DATA_IN", rd, 32'h0000_0001);
    applyStimulus(regAddr(8'h20), 4'h0, 32'h0, 1'b1, rd);
    checkOutput("STATUS rise", rd, 32'h0000_0001);
    applyStimulus(regAddr(8'h20), 4'hF, 32'h0000_0001, 1'b1, rd);
    checkOutput("irq after w1c", 32'(irq), 32'h0);
    gpio_in = 8'h00;
    waitCycles(5);
    checkOutput("no fall irq", 32'(irq), 32'h0);

    // Edge and W1C on the same bit in the same cycle
    applyStimulus(regAddr(8'h18), 4'hF, 32'h0000_0005, 1'b1, rd);
    gpio_in = 8'h04;
    waitCycles(4);
    checkOutput("bit2 armed", 32'(irq), 32'h1);
    gpio_in = 8'h00;
    waitCycles(4);
    checkOutput("bit2 held", 32'(irq), 32'h1);
    gpio_in = 8'h04;
    waitCycles(2);
    applyStimulus(regAddr(8'h20), 4'hF, 32'h0000_0004, 1'b1, rd);
    applyStimulus(regAddr(8'h20), 4'h0, 32'h0, 1'b1, rd);
    checkOutput("set beats clear", rd, 32'h0000_0004);
    pulses0 = ready_pulses;
    applyStimulus({BASE + 8'h01, 24'h0}, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
    waitCycles(1);
    checkOutput("foreign region pulses", 32'(ready_pulses - pulses0), 32'h0);

    // Pins high through reset must not raise edges once enabled
    gpio_in = 8'hFF;
    resetn = 1'b0;
    waitCycles(3);
    resetn = 1'b1;
    applyStimulus(regAddr(8'h18), 4'hF, 32'h0000_00FF, 1'b1, rd);
    waitCycles(8);
    applyStimulus(regAddr(8'h20), 4'h0, 32'h0, 1'b1, rd);
    checkOutput("primed STATUS", rd, 32'h0);
    checkOutput("primed irq", 32'(irq), 32'h0);
    checkOutput("oe after re-reset", 32'(gpio_oe), 32'h0);
    applyStimulus(regAddr(8'h00), 4'h0, 32'h0, 1'b1, rd);
    checkOutput("DATA_OUT re-reset", rd, 32'h0000_00A5);
    gpio_in = 8'hFE;
    waitCycles(4);
    gpio_in = 8'hFF;
    waitCycles(4);
    checkOutput("edge after priming", 32'(irq), 32'h1);

    waitCycles(2);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
